// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: arbiter state encoding, legal parameter ranges and their check
package serial_bus_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        CONNECT = 3'd2,
        BUSY    = 3'd3,
        SPLIT   = 3'd4
    } state_t;
    localparam int MIN_MASTERS = 2;
    localparam int MAX_MASTERS = 4;
    localparam int MIN_SLAVES  = 2;
    localparam int MAX_SLAVES  = 8;
    localparam int MIN_SPLIT   = 1;
    localparam int MAX_SPLIT   = 15;
    function automatic bit params_ok(int nm, int ns, int aw, int sl);
        return nm >= MIN_MASTERS && nm <= MAX_MASTERS && ns >= MIN_SLAVES && ns <= MAX_SLAVES &&
               (1 << aw) >= ns && sl >= MIN_SPLIT && sl <= MAX_SPLIT;
    endfunction
endpackage

// File: rtl/serial_bus_arbiter_if.sv
// serial_bus_arbiter_if: per-bit master and slave bus signals; slave modport is the arbiter's view
interface serial_bus_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 3
);
    logic [N_MASTERS-1:0] m_request, m_address_valid, m_valid, m_address, m_data, m_write_en;
    logic [N_MASTERS-1:0] m_data_out, m_valid_in, m_ready, m_available;
    logic [N_SLAVES-1:0]  s_address, s_data, s_valid, s_write_en;
    logic [N_SLAVES-1:0]  s_data_in, s_valid_out, s_ready;
    modport master (
        output m_request, m_address_valid, m_valid, m_address, m_data, m_write_en,
        output s_data_in, s_valid_out, s_ready,
        input  m_data_out, m_valid_in, m_ready, m_available,
        input  s_address, s_data, s_valid, s_write_en
    );
    modport slave (
        input  m_request, m_address_valid, m_valid, m_address, m_data, m_write_en,
        input  s_data_in, s_valid_out, s_ready,
        output m_data_out, m_valid_in, m_ready, m_available,
        output s_address, s_data, s_valid, s_write_en
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot pick of the first set request after ptr, wrapping modulo N
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    logic [N-1:0] cand;
    // Walk from farthest to nearest so the nearest requester overwrites the rest
    always_comb begin
        gnt  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = N'(1) << ((int'(ptr) + k) % N);
            gnt  = |(req & cand) ? cand : gnt;
        end
    end
endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin master arbitration with serial slave addressing.
// Define ARB_SPLIT_EN to let a transfer stalled by its slave yield the bus to another master.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int N_MASTERS   = 2,
    parameter int N_SLAVES    = 3,
    parameter int SADDR_W     = 2,
    parameter int SPLIT_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_bus_arbiter_if.slave  bus,
    output logic [N_MASTERS-1:0] grant,
    output logic [N_SLAVES-1:0]  connect,
    output logic [2:0]           state,
    output logic                 addr_err
);
    localparam int MW = $clog2(N_MASTERS);
    localparam int CW = $clog2(SADDR_W + 1);
    state_t               st;
    logic [MW-1:0]        rr_ptr, gidx;
    logic [SADDR_W-1:0]   sreg;
    logic [CW-1:0]        bit_cnt;
    logic [N_MASTERS-1:0] elig, idle_pick, route_m;
    logic [N_SLAVES-1:0]  slave_sel, route_s;
    logic                 g_req, g_aval, g_valid, g_addr, g_data, g_we, addr_ok, routed;

    if (!params_ok(N_MASTERS, N_SLAVES, SADDR_W, SPLIT_LIMIT)) begin : g_bad_params
        $error("serial_bus_arbiter: parameter out of legal range");
    end

    assign elig      = bus.m_request & bus.m_address_valid;
    assign g_req     = |(grant & bus.m_request);
    assign g_aval    = |(grant & bus.m_address_valid);
    assign g_valid   = |(grant & bus.m_valid);
    assign g_addr    = |(grant & bus.m_address);
    assign g_data    = |(grant & bus.m_data);
    assign g_we      = |(grant & bus.m_write_en);
    // An out-of-range address shifts the one-hot select off the end, leaving it zero
    assign slave_sel = N_SLAVES'(1) << sreg;
    assign addr_ok   = 32'(sreg) < N_SLAVES;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_MASTERS; i++) gidx = grant[i] ? MW'(i) : gidx;
    end

    rr_arbiter #(.N(N_MASTERS)) u_idle_rr (.req(elig), .ptr(rr_ptr), .gnt(idle_pick));

`ifdef ARB_SPLIT_EN
    logic [3:0]           busy_cnt;
    logic [N_MASTERS-1:0] split_pick;
    logic                 split_go;
    rr_arbiter #(.N(N_MASTERS)) u_split_rr (.req(elig & ~grant), .ptr(gidx), .gnt(split_pick));
    assign split_go = busy_cnt >= 4'(SPLIT_LIMIT) && |(elig & ~grant);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_cnt <= '0;
        else          busy_cnt <= (routed && !(|(connect & bus.s_ready))) ? (busy_cnt == 4'd15 ? busy_cnt : busy_cnt + 4'd1) : 4'd0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= IDLE;
            grant    <= '0;
            connect  <= '0;
            rr_ptr   <= MW'(N_MASTERS - 1);
            sreg     <= '0;
            bit_cnt  <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (st)
                IDLE: if (|elig) begin
                    grant   <= idle_pick;
                    sreg    <= '0;
                    bit_cnt <= '0;
                    st      <= ADDR;
                end
                ADDR: if (g_valid) begin
                    sreg    <= SADDR_W'({sreg, g_addr});
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(SADDR_W - 1)) st <= CONNECT;
                end
                CONNECT: if (!addr_ok) begin
                    addr_err <= 1'b1;
                    grant    <= '0;
                    st       <= IDLE;
                end else if (|(slave_sel & bus.s_ready)) begin
                    connect <= slave_sel;
                    st      <= BUSY;
                end
                BUSY: begin
                    if (!g_req) begin
                        grant   <= '0;
                        connect <= '0;
                        rr_ptr  <= gidx;
                        st      <= IDLE;
                    end
`ifdef ARB_SPLIT_EN
                    else if (split_go) begin
                        connect <= '0;
                        st      <= SPLIT;
                    end
`endif
                    else if (g_aval) begin
                        connect <= '0;
                        sreg    <= '0;
                        bit_cnt <= '0;
                        st      <= ADDR;
                    end
                end
`ifdef ARB_SPLIT_EN
                SPLIT: begin
                    grant   <= split_pick;
                    rr_ptr  <= gidx;
                    sreg    <= '0;
                    bit_cnt <= '0;
                    st      <= |split_pick ? ADDR : IDLE;
                end
`endif
                default: begin
                    grant   <= '0;
                    connect <= '0;
                    st      <= IDLE;
                end
            endcase
        end
    end

    assign routed          = st == BUSY;
    assign route_s         = routed ? connect : '0;
    assign route_m         = routed ? grant : '0;
    assign bus.s_address   = route_s & {N_SLAVES{g_addr}};
    assign bus.s_data      = route_s & {N_SLAVES{g_data}};
    assign bus.s_write_en  = route_s & {N_SLAVES{g_we}};
    assign bus.s_valid     = route_s & {N_SLAVES{g_valid}};
    assign bus.m_data_out  = route_m & {N_MASTERS{|(connect & bus.s_data_in)}};
    assign bus.m_valid_in  = route_m & {N_MASTERS{|(connect & bus.s_valid_out)}};
    assign bus.m_ready     = route_m & {N_MASTERS{|(connect & bus.s_ready)}};
    assign bus.m_available = |grant ? grant : '1;
    assign state           = st;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed checks of arbitration, serial addressing, routing, split and reset
module tb_serial_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] grant;
    logic [2:0] connect, state;
    logic       addr_err;
    int         n_tests = 0;
    int         n_fail = 0;

    serial_bus_arbiter_if #(.N_MASTERS(2), .N_SLAVES(3)) bus ();
    serial_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .grant(grant),
        .connect(connect), .state(state), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        bus.m_request = '0; bus.m_address_valid = '0; bus.m_valid = '0;
        bus.m_address = '0; bus.m_data = '0; bus.m_write_en = '0;
        bus.s_data_in = '0; bus.s_valid_out = '0; bus.s_ready = 3'b111;
    endtask

    task automatic request(input int m);
        bus.m_request[m] = 1'b1;
        bus.m_address_valid[m] = 1'b1;
    endtask

    // Called in the first ADDR cycle; returns with the FSM in CONNECT
    task automatic shift_addr(input int m, input logic [1:0] a);
        bus.m_address_valid[m] = 1'b0;
        bus.m_valid[m] = 1'b1;
        bus.m_address[m] = a[1];
        step();
        bus.m_address[m] = a[0];
        step();
        bus.m_valid[m] = 1'b0;
    endtask

    initial begin
        idle_bus();
        #1 reset_n = 1'b0;
        bus.m_request = 2'b11;
        bus.m_address_valid = 2'b11;
        step(); step();
        check("rst_state", state, 0);
        check("rst_grant", grant, 0);
        check("rst_connect", connect, 0);
        check("rst_avail", bus.m_available, 2'b11);
        check("rst_err", addr_err, 0);
        idle_bus();
        reset_n = 1'b1;
        // master 0 alone, address 01 -> slave 1
        request(0);
        step();
        check("m0_grant", grant, 2'b01);
        check("m0_addr_state", state, 1);
        shift_addr(0, 2'b01);
        check("m0_connect_state", state, 2);
        step();
        check("m0_busy", state, 3);
        check("m0_connect", connect, 3'b010);
        bus.m_valid[0] = 1'b1; bus.m_data[0] = 1'b1; bus.m_write_en[0] = 1'b1; bus.m_address[0] = 1'b1;
        #1;
        check("fwd_valid", bus.s_valid, 3'b010);
        check("fwd_data", bus.s_data, 3'b010);
        check("fwd_we", bus.s_write_en, 3'b010);
        check("fwd_addr", bus.s_address, 3'b010);
        bus.s_data_in = 3'b010; bus.s_valid_out = 3'b010;
        #1;
        check("ret_data", bus.m_data_out, 2'b01);
        check("ret_valid", bus.m_valid_in, 2'b01);
        check("ret_ready", bus.m_ready, 2'b01);
        check("busy_avail", bus.m_available, 2'b01);
        bus.s_data_in = 3'b101;
        #1;
        check("ret_unconnected", bus.m_data_out, 2'b00);
        idle_bus();
        bus.m_request[0] = 1'b1;
        bus.m_request[0] = 1'b0;
        step();
        check("drop_state", state, 0);
        check("drop_grant", grant, 0);
        check("drop_connect", connect, 0);
        // master 1 alone, address 10 with a stalled bit
        request(1);
        step();
        check("m1_grant", grant, 2'b10);
        bus.m_address_valid[1] = 1'b0; bus.m_valid[1] = 1'b1; bus.m_address[1] = 1'b1;
        step();
        bus.m_valid[1] = 1'b0;
        step();
        check("stall_state", state, 1);
        bus.m_valid[1] = 1'b1; bus.m_address[1] = 1'b0;
        step();
        bus.m_valid[1] = 1'b0;
        check("stall_connect_state", state, 2);
        step();
        check("m1_connect", connect, 3'b100);
        bus.m_request[1] = 1'b0;
        step();
        // both masters request in two consecutive transactions
        request(0); request(1);
        step();
        check("rr_first", grant, 2'b01);
        shift_addr(0, 2'b00);
        step();
        check("rr_first_connect", connect, 3'b001);
        bus.m_request[0] = 1'b0;
        step();
        check("rr_gap_state", state, 0);
        request(0);
        step();
        check("rr_second", grant, 2'b10);
        // master 1 sends address 3, beyond the three slaves
        shift_addr(1, 2'b11);
        bus.m_request = '0; bus.m_address_valid = '0;
        step();
        check("err_pulse", addr_err, 1);
        check("err_grant", grant, 0);
        check("err_state", state, 0);
        step();
        check("err_single", addr_err, 0);
        // re-address from BUSY
        request(0);
        step();
        check("readdr_grant", grant, 2'b01);
        shift_addr(0, 2'b01);
        step();
        check("readdr_connect1", connect, 3'b010);
        bus.m_address_valid[0] = 1'b1;
        step();
        check("readdr_state", state, 1);
        check("readdr_clear", connect, 0);
        check("readdr_keep", grant, 2'b01);
        bus.m_valid[0] = 1'b1;
        #1;
        check("addr_no_valid", bus.s_valid, 0);
        shift_addr(0, 2'b10);
        step();
        check("readdr_connect2", connect, 3'b100);
        // slave 2 stalls while master 1 waits
        bus.s_ready = 3'b011;
        request(1);
        #1;
        check("stall_ready", bus.m_ready, 0);
        repeat (4) step();
        check("pre_split", state, 3);
        step();
`ifdef ARB_SPLIT_EN
        check("split_state", state, 4);
        step();
        check("split_grant", grant, 2'b10);
        check("split_next", state, 1);
`else
        check("nosplit_state", state, 3);
        step();
        check("nosplit_grant", grant, 2'b01);
        check("nosplit_next", state, 3);
`endif
        reset_n = 1'b0;
        idle_bus();
        step();
        check("abort_state", state, 0);
        reset_n = 1'b1;
        // request drop coincides with the split condition
        request(0);
        step();
        shift_addr(0, 2'b10);
        step();
        check("drop_split_connect", connect, 3'b100);
        bus.s_ready = 3'b011;
        repeat (6) step();
        check("drop_split_busy", state, 3);
        bus.m_request[0] = 1'b0;
        request(1);
        step();
        check("drop_wins_state", state, 0);
        check("drop_wins_grant", grant, 0);
        step();
        check("after_drop_grant", grant, 2'b10);
        check("after_drop_state", state, 1);
        // asynchronous reset in the middle of a BUSY transfer
        shift_addr(1, 2'b01);
        step();
        check("pre_rst_connect", connect, 3'b010);
        bus.m_valid[1] = 1'b1;
        #1;
        check("pre_rst_valid", bus.s_valid, 3'b010);
        reset_n = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_grant", grant, 0);
        check("async_connect", connect, 0);
        check("async_valid", bus.s_valid, 0);
        check("async_ready", bus.m_ready, 0);
        check("async_avail", bus.m_available, 2'b11);
        idle_bus();
        step();
        reset_n = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
